// File: rtl/rename_reg_file.sv
// Purpose : architectural register file with ROB-tag renaming, two source reads, NCOMMIT commits/cycle.
// Latency : reads and ROB lookup tags are combinational; commit/rename/clear are visible the cycle after the edge.
// Backpress: rdy low freezes all state while the combinational outputs stay valid; there is no other stall.
//
// Ports:
//   clk, rst (sync, active-high), rdy (global enable), clear (flush all busy bits)
//   dec_valid/dec_rd/dec_tag : rename of one destination per cycle
//   dec_rs1/dec_rs2 -> rs*_val/rs*_rdy/rs*_tag : resolved source operands
//   rob_q*_tag -> ROB, rob_q*_ok/rob_q*_val <- ROB : forwarding lookup for busy sources
//   cm_valid/cm_rd/cm_tag/cm_val : NCOMMIT flattened commit ports, port 0 oldest
// Build option: define RF_COMMIT_BYPASS_EN to let busy sources pick up same-cycle commit values.
module rename_reg_file #(
   parameter int XLEN    = 32,
   parameter int NREG    = 32,
   parameter int TAG_W   = 4,
   parameter int NCOMMIT = 2,
   localparam int RW     = $clog2(NREG)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rdy,
   input  logic                     clear,
   input  logic                     dec_valid,
   input  logic [RW-1:0]            dec_rs1,
   input  logic [RW-1:0]            dec_rs2,
   input  logic [RW-1:0]            dec_rd,
   input  logic [TAG_W-1:0]         dec_tag,
   output logic [XLEN-1:0]          rs1_val,
   output logic [XLEN-1:0]          rs2_val,
   output logic                     rs1_rdy,
   output logic                     rs2_rdy,
   output logic [TAG_W-1:0]         rs1_tag,
   output logic [TAG_W-1:0]         rs2_tag,
   output logic [TAG_W-1:0]         rob_q1_tag,
   output logic [TAG_W-1:0]         rob_q2_tag,
   input  logic                     rob_q1_ok,
   input  logic                     rob_q2_ok,
   input  logic [XLEN-1:0]          rob_q1_val,
   input  logic [XLEN-1:0]          rob_q2_val,
   input  logic [NCOMMIT-1:0]       cm_valid,
   input  logic [NCOMMIT*RW-1:0]    cm_rd,
   input  logic [NCOMMIT*TAG_W-1:0] cm_tag,
   input  logic [NCOMMIT*XLEN-1:0]  cm_val
);

   typedef struct packed {
      logic [XLEN-1:0]  val;
      logic             rdy;
      logic [TAG_W-1:0] tag;
   } rd_res_t;

   logic [XLEN-1:0]  val_q [NREG];
   logic [TAG_W-1:0] tag_q [NREG];
   logic [NREG-1:0]  busy_q;

   // Unflattened commit ports.
   logic [RW-1:0]    cm_rd_a  [NCOMMIT];
   logic [TAG_W-1:0] cm_tag_a [NCOMMIT];
   logic [XLEN-1:0]  cm_val_a [NCOMMIT];

   always_comb begin
      for (int k = 0; k < NCOMMIT; k++) begin
         cm_rd_a[k]  = cm_rd[k*RW +: RW];
         cm_tag_a[k] = cm_tag[k*TAG_W +: TAG_W];
         cm_val_a[k] = cm_val[k*XLEN +: XLEN];
      end
   end

   // Resolve one source operand against pre-edge state.
   function automatic rd_res_t resolve(input logic [RW-1:0]   idx,
                                       input logic            ok,
                                       input logic [XLEN-1:0] rob_val);
      rd_res_t r;
      r.val = '0;
      r.rdy = 1'b1;
      r.tag = '0;
      if (idx == '0) begin
         r.val = '0;
      end else if (!busy_q[idx]) begin
         r.val = val_q[idx];
      end else if (ok) begin
         r.val = rob_val;
      end else begin
         r.rdy = 1'b0;
         r.tag = tag_q[idx];
`ifdef RF_COMMIT_BYPASS_EN
         // Ascending scan so the highest matching port is the one left standing.
         for (int k = 0; k < NCOMMIT; k++) begin
            if (cm_valid[k] && cm_rd_a[k] == idx && cm_tag_a[k] == tag_q[idx]) begin
               r.val = cm_val_a[k];
               r.rdy = 1'b1;
               r.tag = '0;
            end
         end
`endif
      end
      return r;
   endfunction

   rd_res_t res1;
   rd_res_t res2;

   assign res1 = resolve(dec_rs1, rob_q1_ok, rob_q1_val);
   assign res2 = resolve(dec_rs2, rob_q2_ok, rob_q2_val);

   assign rs1_val    = res1.val;
   assign rs1_rdy    = res1.rdy;
   assign rs1_tag    = res1.tag;
   assign rs2_val    = res2.val;
   assign rs2_rdy    = res2.rdy;
   assign rs2_tag    = res2.tag;
   assign rob_q1_tag = tag_q[dec_rs1];
   assign rob_q2_tag = tag_q[dec_rs2];

   // A rename is suppressed by a flush and never targets x0.
   logic ren;
   assign ren = dec_valid && (dec_rd != '0) && !clear;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            val_q[i] <= '0;
            tag_q[i] <= '0;
         end
         busy_q <= '0;
      end else if (rdy) begin
         // Later ports' NBAs land last, so the highest port's value wins.
         // Busy-clear compares against the pre-edge tag for every port.
         for (int k = 0; k < NCOMMIT; k++) begin
            if (cm_valid[k] && cm_rd_a[k] != '0) begin
               val_q[cm_rd_a[k]] <= cm_val_a[k];
               if (busy_q[cm_rd_a[k]] && tag_q[cm_rd_a[k]] == cm_tag_a[k] &&
                   !(ren && dec_rd == cm_rd_a[k]))
                  busy_q[cm_rd_a[k]] <= 1'b0;
            end
         end
         // Flush and rename are ordered after commits so they override busy-clears.
         if (clear) begin
            busy_q <= '0;
         end else if (ren) begin
            busy_q[dec_rd] <= 1'b1;
            tag_q[dec_rd]  <= dec_tag;
         end
      end
   end

endmodule

// File: tb/tb_rename_reg_file.sv
// Purpose : self-checking bench for rename_reg_file with a behavioural register/rename model.
// Latency : inputs driven after posedge, outputs checked 1 ns later, model advanced at each edge.
// Backpress: rdy is toggled in directed and random phases to exercise the freeze behaviour.
module tb_rename_reg_file;
   localparam int XLEN  = 32;
   localparam int NREG  = 32;
   localparam int TAG_W = 4;
   localparam int NC    = 2;
   localparam int RW    = 5;

   logic                  clk = 1'b0;
   logic                  rst, rdy, clear, dec_valid;
   logic [RW-1:0]         dec_rs1, dec_rs2, dec_rd;
   logic [TAG_W-1:0]      dec_tag;
   logic [XLEN-1:0]       rs1_val, rs2_val;
   logic                  rs1_rdy, rs2_rdy;
   logic [TAG_W-1:0]      rs1_tag, rs2_tag, rob_q1_tag, rob_q2_tag;
   logic                  rob_q1_ok, rob_q2_ok;
   logic [XLEN-1:0]       rob_q1_val, rob_q2_val;
   logic [NC-1:0]         cm_valid;
   logic [NC*RW-1:0]      cm_rd;
   logic [NC*TAG_W-1:0]   cm_tag;
   logic [NC*XLEN-1:0]    cm_val;

   rename_reg_file #(.XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .NCOMMIT(NC)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
      .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_tag(dec_tag),
      .rs1_val(rs1_val), .rs2_val(rs2_val), .rs1_rdy(rs1_rdy), .rs2_rdy(rs2_rdy),
      .rs1_tag(rs1_tag), .rs2_tag(rs2_tag), .rob_q1_tag(rob_q1_tag), .rob_q2_tag(rob_q2_tag),
      .rob_q1_ok(rob_q1_ok), .rob_q2_ok(rob_q2_ok), .rob_q1_val(rob_q1_val), .rob_q2_val(rob_q2_val),
      .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_tag(cm_tag), .cm_val(cm_val)
   );

   always #5 clk = ~clk;

   // Reference state: what each architectural register holds, whether it waits on a producer, and which one.
   logic [XLEN-1:0]  m_val [NREG];
   logic [TAG_W-1:0] m_tag [NREG];
   logic [NREG-1:0]  m_busy;
   logic [XLEN-1:0]  n_val [NREG];
   logic [TAG_W-1:0] n_tag [NREG];
   logic [NREG-1:0]  n_busy;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic model_read(input logic [RW-1:0] idx, input logic ok, input logic [XLEN-1:0] rv,
                             output logic [XLEN-1:0] v, output logic r, output logic [TAG_W-1:0] t);
      v = '0; r = 1'b1; t = '0;
      if (idx == 0) v = '0;
      else if (!m_busy[idx]) v = m_val[idx];
      else if (ok) v = rv;
      else begin
         r = 1'b0;
         t = m_tag[idx];
`ifdef RF_COMMIT_BYPASS_EN
         for (int k = 0; k < NC; k++)
            if (cm_valid[k] && cm_rd[k*RW +: RW] == idx && cm_tag[k*TAG_W +: TAG_W] == m_tag[idx]) begin
               v = cm_val[k*XLEN +: XLEN];
               r = 1'b1;
               t = '0;
            end
`endif
      end
   endtask

   // Let combinational outputs settle, then compare every read output with the model.
   task automatic look();
      logic [XLEN-1:0] v; logic r; logic [TAG_W-1:0] t;
      #1;
      model_read(dec_rs1, rob_q1_ok, rob_q1_val, v, r, t);
      chk("rs1_val", rs1_val, v);
      chk("rs1_rdy", rs1_rdy, r);
      chk("rs1_tag", rs1_tag, t);
      chk("rob_q1_tag", rob_q1_tag, m_tag[dec_rs1]);
      model_read(dec_rs2, rob_q2_ok, rob_q2_val, v, r, t);
      chk("rs2_val", rs2_val, v);
      chk("rs2_rdy", rs2_rdy, r);
      chk("rs2_tag", rs2_tag, t);
      chk("rob_q2_tag", rob_q2_tag, m_tag[dec_rs2]);
   endtask

   // Apply one clock edge to both the model and the DUT.
   task automatic tick();
      logic [RW-1:0] rd;
      logic ren;
      n_val = m_val; n_tag = m_tag; n_busy = m_busy;
      ren = dec_valid && dec_rd != 0 && !clear;
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin n_val[i] = '0; n_tag[i] = '0; end
         n_busy = '0;
      end else if (rdy) begin
         for (int k = 0; k < NC; k++) begin
            rd = cm_rd[k*RW +: RW];
            if (cm_valid[k] && rd != 0) begin
               n_val[rd] = cm_val[k*XLEN +: XLEN];
               if (m_busy[rd] && m_tag[rd] == cm_tag[k*TAG_W +: TAG_W] && !(ren && dec_rd == rd))
                  n_busy[rd] = 1'b0;
            end
         end
         if (clear) n_busy = '0;
         else if (ren) begin n_busy[dec_rd] = 1'b1; n_tag[dec_rd] = dec_tag; end
      end
      @(posedge clk);
      #1;
      m_val = n_val; m_tag = n_tag; m_busy = n_busy;
   endtask

   task automatic idle();
      rst = 1'b0; rdy = 1'b1; clear = 1'b0; dec_valid = 1'b0;
      dec_rd = '0; dec_tag = '0; rob_q1_ok = 1'b0; rob_q2_ok = 1'b0;
      rob_q1_val = '0; rob_q2_val = '0;
      cm_valid = '0; cm_rd = '0; cm_tag = '0; cm_val = '0;
   endtask

   task automatic set_cm(input int k, input logic [RW-1:0] rd, input logic [TAG_W-1:0] t, input logic [XLEN-1:0] v);
      cm_valid[k] = 1'b1;
      cm_rd[k*RW +: RW] = rd;
      cm_tag[k*TAG_W +: TAG_W] = t;
      cm_val[k*XLEN +: XLEN] = v;
   endtask

   task automatic rename(input logic [RW-1:0] rd, input logic [TAG_W-1:0] t);
      dec_valid = 1'b1; dec_rd = rd; dec_tag = t;
   endtask

   initial begin
      for (int i = 0; i < NREG; i++) begin m_val[i] = '0; m_tag[i] = '0; end
      m_busy = '0;
      idle();
      dec_rs1 = '0; dec_rs2 = '0;
      rst = 1'b1;
      tick();

      // Reset state.
      idle(); dec_rs1 = 5; dec_rs2 = 0;
      look();
      chk("reset_rs1_rdy", rs1_rdy, 1); chk("reset_rs1_val", rs1_val, 0); chk("reset_rs2_tag", rs2_tag, 0);

      // Rename x3 -> tag 7, then ROB forwarding.
      rename(3, 7); look(); tick();
      idle(); dec_rs1 = 3; look();
      chk("x3_busy_rdy", rs1_rdy, 0); chk("x3_busy_tag", rs1_tag, 7);
      rob_q1_ok = 1'b1; rob_q1_val = 32'hAB; look();
      chk("x3_rob_val", rs1_val, 32'hAB); chk("x3_rob_rdy", rs1_rdy, 1);

      // Commit x3 while renaming x3: value lands, busy stays with the new tag.
      idle(); set_cm(0, 3, 7, 32'h55); rename(3, 9); look(); tick();
      idle(); look();
      chk("x3_rename_wins_rdy", rs1_rdy, 0); chk("x3_new_tag", rs1_tag, 9);
      clear = 1'b1; look(); tick();
      idle(); look();
      chk("x3_commit_val", rs1_val, 32'h55); chk("x3_tag_kept", rob_q1_tag, 9);

      // Two ports commit x4; highest port's value wins.
      rename(4, 3); tick();
      idle(); set_cm(0, 4, 2, 1); set_cm(1, 4, 3, 2); tick();
      idle(); dec_rs1 = 4; look();
      chk("x4_val_p1", rs1_val, 2); chk("x4_cleared", rs1_rdy, 1);
      rename(4, 5); tick();
      idle(); set_cm(0, 4, 2, 1); set_cm(1, 4, 3, 2); tick();
      idle(); look();
      chk("x4_still_busy", rs1_rdy, 0); chk("x4_tag5", rs1_tag, 5);
      clear = 1'b1; tick();
      idle(); look(); chk("x4_val_after_clear", rs1_val, 2);

      // Clear beats rename; x0 stays zero.
      rename(6, 2); tick();
      idle(); clear = 1'b1; rename(6, 1); tick();
      idle(); dec_rs1 = 6; look();
      chk("x6_not_busy", rs1_rdy, 1); chk("x6_tag_unchanged", rob_q1_tag, 2);
      rename(0, 3); set_cm(0, 0, 0, 32'hFF); tick();
      idle(); dec_rs1 = 0; dec_rs2 = 0; look();
      chk("x0_val", rs1_val, 0); chk("x0_rdy", rs2_rdy, 1);

      // Same-cycle commit of a busy source.
      rename(8, 4); tick();
      idle(); dec_rs1 = 8; set_cm(0, 8, 4, 32'h77); look();
`ifdef RF_COMMIT_BYPASS_EN
      chk("x8_bypass_val", rs1_val, 32'h77); chk("x8_bypass_rdy", rs1_rdy, 1);
`else
      chk("x8_nobypass_rdy", rs1_rdy, 0); chk("x8_nobypass_tag", rs1_tag, 4);
`endif
      tick();

      // Freeze: nothing changes while rdy is low.
      idle(); rdy = 1'b0; rename(9, 6); set_cm(0, 9, 0, 32'h1234); dec_rs1 = 9; tick();
      idle(); look(); chk("x9_frozen_val", rs1_val, 0); chk("x9_frozen_rdy", rs1_rdy, 1);

      // Reset mid-stream beats everything else in the cycle.
      rename(10, 3); tick();
      idle(); rst = 1'b1; rename(11, 2); set_cm(0, 10, 3, 32'h99); tick();
      idle(); dec_rs1 = 10; dec_rs2 = 11; look();
      chk("x10_reset_val", rs1_val, 0); chk("x11_reset_rdy", rs2_rdy, 1);

      // Randomised traffic over a small register window to force collisions.
      for (int n = 0; n < 500; n++) begin
         idle();
         rst       = ($urandom_range(0, 99) == 0);
         rdy       = ($urandom_range(0, 9) != 0);
         clear     = ($urandom_range(0, 19) == 0);
         dec_valid = $urandom_range(0, 1);
         dec_rd    = RW'($urandom_range(0, 7));
         dec_tag   = TAG_W'($urandom);
         dec_rs1   = RW'($urandom_range(0, 7));
         dec_rs2   = RW'($urandom_range(0, 7));
         rob_q1_ok = ($urandom_range(0, 3) == 0);
         rob_q2_ok = ($urandom_range(0, 3) == 0);
         rob_q1_val = $urandom;
         rob_q2_val = $urandom;
         for (int k = 0; k < NC; k++) begin
            logic [RW-1:0] rd;
            rd = RW'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1)
               set_cm(k, rd, ($urandom_range(0, 1) == 1) ? m_tag[rd] : TAG_W'($urandom), $urandom);
         end
         look();
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/rename_reg_file.md
# rename_reg_file

Parametrised architectural register file with ROB-tag renaming for the out-of-order core. It holds committed register values plus a per-register busy bit and producing ROB tag. It resolves two decode source operands per cycle, reading directly or forwarding from the ROB, and absorbs up to `NCOMMIT` in-order ROB commits per cycle. Compared with the single-commit register file it replaces, it adds configurable width, depth, tag size and commit count, an explicit ready flag instead of a sentinel tag, and optional same-cycle commit bypass.

## Interface
Parameters:
- `XLEN`, 32, data width.
- `NREG`, 32, architectural register count; power of 2; register 0 hardwired to zero.
- `TAG_W`, 4, ROB tag width.
- `NCOMMIT`, 2, commit ports, 1..4; port 0 is the oldest.

Ports (`RW = clog2(NREG)`):
- `clk` in 1, clock.
- `rst` in 1, synchronous, active-high reset.
- `rdy` in 1, global enable; when low, no state changes.
- `clear` in 1, misprediction flush.
- `dec_valid` in 1, the decode slot renames `dec_rd` this cycle.
- `dec_rs1`, `dec_rs2`, `dec_rd` in RW, decode register indices.
- `dec_tag` in TAG_W, ROB entry allocated to the decode instruction.
- `rs1_val`, `rs2_val` out XLEN, operand values (0 when not ready).
- `rs1_rdy`, `rs2_rdy` out 1, operand value valid.
- `rs1_tag`, `rs2_tag` out TAG_W, producer tag when not ready; otherwise 0.
- `rob_q1_tag`, `rob_q2_tag` out TAG_W, current tag of `dec_rs1` / `dec_rs2`, sent to the ROB for lookup.
- `rob_q1_ok`, `rob_q2_ok` in 1, the ROB entry has its result.
- `rob_q1_val`, `rob_q2_val` in XLEN, ROB result values.
- `cm_valid` in NCOMMIT, per-port commit strobe.
- `cm_rd` in NCOMMIT*RW, flattened commit destinations; port k occupies bits [k*RW +: RW].
- `cm_tag` in NCOMMIT*TAG_W, flattened commit tags.
- `cm_val` in NCOMMIT*XLEN, flattened commit values.

## Operation
State: `val[NREG]`, `busy[NREG]`, `tag[NREG]`.

Reset: all `val` = 0, all `busy` = 0, all `tag` = 0. After reset, every read returns val = 0, rdy = 1, tag = 0.

Read (combinational, per source s):
- Source index 0, or `busy` clear: val = `val[s]`, rdy = 1, tag = 0.
- `busy` set and the ROB reports ok: val = ROB value, rdy = 1, tag = 0.
- Otherwise: the commit bypass applies if compiled in (see Configuration). If no bypass hit: val = 0, rdy = 0, tag = `tag[s]`.
- Reads always see state from before this cycle's rename, so an instruction whose rs equals its rd gets the old mapping.

Commit (port k, when `cm_valid[k]` is set and `cm_rd` ≠ 0):
- Write `val[cm_rd] = cm_val`.
- Clear `busy[cm_rd]` only if:
  - `busy` is set, and
  - `tag[cm_rd]` equals `cm_tag`, and
  - the register is not being renamed this cycle.
- If several ports commit the same rd, the highest-numbered port's value wins. Each port's busy-clear test uses the pre-cycle tag.

Rename (`dec_valid` set, `dec_rd` ≠ 0, `clear` low):
- `busy[dec_rd]` = 1, `tag[dec_rd]` = `dec_tag`.
- Rename overrides any commit clear on the same register.

Clear:
- All `busy` bits = 0 at the next edge.
- Commit value writes in the same cycle still apply.
- Rename is ignored.
- `tag` values are unchanged.

Priority: `rst` > `!rdy` (freeze) > {commit writes, then clear or rename}.

## Timing
- Read outputs and `rob_q*_tag` have zero latency (combinational from the decode indices and current state).
- Commit, rename and clear effects become visible on read outputs the cycle after the edge.
- When `rdy` is low, combinational outputs stay valid and state holds.
- Reset asserted mid-stream wins over all same-cycle commit, rename and clear activity.

## Configuration
`RF_COMMIT_BYPASS_EN`:
- Defined: a read of a busy register whose ROB lookup is not ok, but which matches a same-cycle commit (`cm_valid[k]`, `cm_rd` = s, `cm_tag` = `tag[s]`), returns `cm_val[k]` with rdy = 1. If several ports match, the highest port wins.
- Undefined: such a read returns rdy = 0 with the tag, and the operand resolves through the ROB or CDB later.

## Test plan
- Reset, then read rs1 = 5, rs2 = 0 → both val = 0, rdy = 1, tag = 0.
- Rename x3 → tag 7. Next cycle read x3 with `rob_q1_ok` = 0 → rdy = 0, tag = 7. Then drive `rob_q1_ok` = 1, val = 0xAB → rdy = 1, val = 0xAB.
- Commit x3 with tag 7, value 0x55, while decode renames x3 → tag 9 in the same cycle → next cycle `val[3]` = 0x55, `busy[3]` = 1, `tag[3]` = 9.
- Port 0 commits x4 = 1 (tag 2) and port 1 commits x4 = 2 (tag 3), with `tag[4]` = 3 → `val[4]` = 2 and busy clears. Repeat with `tag[4]` = 5 → value = 2 and busy stays 1.
- `clear` together with rename x6 → x6 not busy next cycle; x0 rename or commit of 0xFF → x0 still reads 0.
- With `RF_COMMIT_BYPASS_EN`: x8 busy with tag 4, ROB not ok, same-cycle commit of x8 tag 4 value 0x77 → `rs1_val` = 0x77, rdy = 1. Without the macro → rdy = 0, tag = 4.
